bcd_updown_counter_n: RTL and testbench

//  Parametrised N-digit BCD up/down counter driven by the 1 Hz timebase.

---
 rtl/bcd_updown_counter_n.sv | 142 ++++++++++++++
 tb/tb_bcd_updown_counter_n.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter_n.sv
// bcd_updown_counter_n: N-digit BCD up/down counter on the 1 Hz timebase.
// Parallel load with per-nibble clamp to 9, terminal-count flag, a buzzer
// pulse of programmable length, and an optional halt-at-terminal mode.
// Ports:
//   clk_1Hz      counting clock
//   reset        asynchronous, active-high reset
//   load_i       synchronous load strobe (highest priority after reset)
//   load_val_i   packed BCD value to load
//   updown_i     1 = count up, 0 = count down
//   stop_i       1 = hold the count
//   digits_o     current count, digit k at [4k+3:4k]
//   tc_o         terminal count (all 9s up / all 0s down), combinational
//   halted_o     high while halted at terminal (AUTO_RELOAD=0 only)
//   buzzer_o     terminal-count alarm pulse, BUZZ_LEN cycles long
module bcd_updown_counter_n #(
    parameter int unsigned NDIG        = 2,
    parameter int unsigned BUZZ_LEN    = 1,
    parameter int unsigned AUTO_RELOAD = 1
) (
    input  logic                clk_1Hz,
    input  logic                reset,
    input  logic                load_i,
    input  logic [4*NDIG-1:0]   load_val_i,
    input  logic                updown_i,
    input  logic                stop_i,
    output logic [4*NDIG-1:0]   digits_o,
    output logic                tc_o,
    output logic                halted_o,
    output logic                buzzer_o
);

    localparam int unsigned DW = 4 * NDIG;
    localparam int unsigned BW = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   digits_q;
    logic [BW-1:0]   buzz_q;
    logic [BW-1:0]   buzz_d;
    logic            buzzer_q;
    logic [DW-1:0]   count_c;
    logic [DW-1:0]   load_clamp_c;
    logic            all9_c;
    logic            all0_c;
    logic            term_evt_c;

    // Load value with any nibble above 9 forced to 9.
    always_comb begin
        load_clamp_c = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (load_val_i[4*k +: 4] > 4'd9) begin
                load_clamp_c[4*k +: 4] = 4'd9;
            end else begin
                load_clamp_c[4*k +: 4] = load_val_i[4*k +: 4];
            end
        end
    end

    // Ripple BCD increment/decrement; the carry/borrow out of the top digit
    // is dropped, which gives the natural all-9s <-> all-0s wrap.
    always_comb begin
        logic       carry;
        logic [3:0] nib;
        count_c = digits_q;
        all9_c  = 1'b1;
        all0_c  = 1'b1;
        carry   = 1'b1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            nib = digits_q[4*k +: 4];
            if (nib != 4'd9) all9_c = 1'b0;
            if (nib != 4'd0) all0_c = 1'b0;
            if (carry) begin
                if (updown_i) begin
                    count_c[4*k +: 4] = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
                    carry             = (nib == 4'd9);
                end else begin
                    count_c[4*k +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
                    carry             = (nib == 4'd0);
                end
            end
        end
    end

    assign tc_o       = updown_i ? all9_c : all0_c;
    assign term_evt_c = (state_q == RUN) && !stop_i && tc_o;

    // Buzz counter holds the remaining pulse cycles including the current one.
    always_comb begin
        buzz_d = '0;
        if (load_i) begin
            buzz_d = '0;
        end else if (term_evt_c) begin
            buzz_d = BW'(BUZZ_LEN);
        end else if (buzz_q != '0) begin
            buzz_d = buzz_q - BW'(1);
        end
    end

    // State, count and buzzer registers.
    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            digits_q <= '0;
            buzz_q   <= '0;
            buzzer_q <= 1'b0;
        end else begin
            buzz_q   <= buzz_d;
            buzzer_q <= (buzz_d != '0);
            if (load_i) begin
                digits_q <= load_clamp_c;
                state_q  <= RUN;
            end else begin
                case (state_q)
                    RUN: begin
                        if (!stop_i) begin
                            if (tc_o && (AUTO_RELOAD == 0)) begin
                                state_q <= HALT;
                            end else begin
                                digits_q <= count_c;
                            end
                        end
                    end
                    HALT: begin
                        state_q <= HALT;
                    end
                    default: begin
                        state_q <= RUN;
                    end
                endcase
            end
        end
    end

    assign digits_o = digits_q;
    assign buzzer_o = buzzer_q;
    assign halted_o = (state_q == HALT);

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Testbench for bcd_updown_counter_n: three instances cover the wrap/BUZZ_LEN=1,
// 3-digit/BUZZ_LEN=3 and halt-at-terminal configurations.
module tb_bcd_updown_counter_n;

    logic clk_1Hz = 1'b0;
    logic reset;

    logic        ld0, ud0, st0, tc0, h0, bz0;
    logic [7:0]  lv0, dig0;
    logic        ld1, ud1, st1, tc1, h1, bz1;
    logic [11:0] lv1, dig1;
    logic        ld2, ud2, st2, tc2, h2, bz2;
    logic [7:0]  lv2, dig2;

    bcd_updown_counter_n #(.NDIG(2), .BUZZ_LEN(1), .AUTO_RELOAD(1)) u0 (
        .clk_1Hz(clk_1Hz), .reset(reset), .load_i(ld0), .load_val_i(lv0),
        .updown_i(ud0), .stop_i(st0), .digits_o(dig0), .tc_o(tc0),
        .halted_o(h0), .buzzer_o(bz0));

    bcd_updown_counter_n #(.NDIG(3), .BUZZ_LEN(3), .AUTO_RELOAD(1)) u1 (
        .clk_1Hz(clk_1Hz), .reset(reset), .load_i(ld1), .load_val_i(lv1),
        .updown_i(ud1), .stop_i(st1), .digits_o(dig1), .tc_o(tc1),
        .halted_o(h1), .buzzer_o(bz1));

    bcd_updown_counter_n #(.NDIG(2), .BUZZ_LEN(2), .AUTO_RELOAD(0)) u2 (
        .clk_1Hz(clk_1Hz), .reset(reset), .load_i(ld2), .load_val_i(lv2),
        .updown_i(ud2), .stop_i(st2), .digits_o(dig2), .tc_o(tc2),
        .halted_o(h2), .buzzer_o(bz2));

    always #5 clk_1Hz = ~clk_1Hz;

    typedef struct {
        int          id;
        logic        ld;
        logic [11:0] lv;
        logic        ud;
        logic        st;
        logic [11:0] dig;
        logic        tc;
        logic        h;
        logic        bz;
    } vec_t;

    typedef struct {
        int          id;
        int          tag;
        logic [11:0] dig;
        logic        tc;
        logic        h;
        logic        bz;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   tagn     = 0;

    function automatic vec_t mk(int id, logic ld, logic [11:0] lv, logic ud, logic st,
                                logic [11:0] dig, logic tc, logic h, logic bz);
        vec_t v;
        v.id = id; v.ld = ld; v.lv = lv; v.ud = ud; v.st = st;
        v.dig = dig; v.tc = tc; v.h = h; v.bz = bz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one vector, queue its expectation, then compare after the edge.
    task automatic step(input vec_t v);
        exp_t e;
        logic [11:0] a_dig;
        logic a_tc, a_h, a_bz;
        case (v.id)
            0: begin ld0 = v.ld; lv0 = v.lv[7:0]; ud0 = v.ud; st0 = v.st; end
            1: begin ld1 = v.ld; lv1 = v.lv;      ud1 = v.ud; st1 = v.st; end
            default: begin ld2 = v.ld; lv2 = v.lv[7:0]; ud2 = v.ud; st2 = v.st; end
        endcase
        e.id = v.id; e.tag = tagn; e.dig = v.dig; e.tc = v.tc; e.h = v.h; e.bz = v.bz;
        sb.push_back(e);
        tagn++;
        @(posedge clk_1Hz);
        #1;
        e = sb.pop_front();
        case (e.id)
            0: begin a_dig = {4'h0, dig0}; a_tc = tc0; a_h = h0; a_bz = bz0; end
            1: begin a_dig = dig1;         a_tc = tc1; a_h = h1; a_bz = bz1; end
            default: begin a_dig = {4'h0, dig2}; a_tc = tc2; a_h = h2; a_bz = bz2; end
        endcase
        chk($sformatf("v%0d u%0d digits", e.tag, e.id), a_dig, e.dig);
        chk($sformatf("v%0d u%0d tc", e.tag, e.id), {11'd0, a_tc}, {11'd0, e.tc});
        chk($sformatf("v%0d u%0d halted", e.tag, e.id), {11'd0, a_h}, {11'd0, e.h});
        chk($sformatf("v%0d u%0d buzzer", e.tag, e.id), {11'd0, a_bz}, {11'd0, e.bz});
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Up wrap with one-cycle buzzer.
        vecs.push_back(mk(0, 1, 12'h097, 1, 0, 12'h097, 0, 0, 0));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 12'h098, 0, 0, 0));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 12'h099, 1, 0, 0));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 12'h000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 12'h001, 0, 0, 0));
        // Down wrap.
        vecs.push_back(mk(0, 1, 12'h001, 0, 0, 12'h001, 0, 0, 0));
        vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h099, 0, 0, 1));
        // Stop holds; load clamps.
        vecs.push_back(mk(0, 1, 12'h042, 1, 0, 12'h042, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 12'h000, 1, 1, 12'h042, 0, 0, 0));
        vecs.push_back(mk(0, 1, 12'h0AB, 1, 1, 12'h099, 1, 0, 0));
        // Load and stop at terminal: load wins, no buzzer.
        vecs.push_back(mk(0, 1, 12'h055, 1, 1, 12'h055, 0, 0, 0));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 12'h056, 0, 0, 0));
        // Load at terminal without stop suppresses the event.
        vecs.push_back(mk(0, 1, 12'h099, 1, 0, 12'h099, 1, 0, 0));
        vecs.push_back(mk(0, 1, 12'h055, 1, 0, 12'h055, 0, 0, 0));
        vecs.push_back(mk(0, 1, 12'h0F3, 0, 1, 12'h093, 0, 0, 0));
        // Three digits, BUZZ_LEN=3.
        vecs.push_back(mk(1, 1, 12'h100, 0, 0, 12'h100, 0, 0, 0));
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 12'h099, 0, 0, 0));
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 12'h098, 0, 0, 0));
        vecs.push_back(mk(1, 1, 12'h001, 0, 0, 12'h001, 0, 0, 0));
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 12'h000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 12'h999, 0, 0, 1));
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 12'h998, 0, 0, 1));
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 12'h997, 0, 0, 1));
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 12'h996, 0, 0, 0));
        vecs.push_back(mk(1, 1, 12'h199, 1, 0, 12'h199, 0, 0, 0));
        vecs.push_back(mk(1, 0, 12'h000, 1, 0, 12'h200, 0, 0, 0));
        vecs.push_back(mk(1, 1, 12'hA5F, 1, 1, 12'h959, 0, 0, 0));
        // Buzzer keeps timing out during stop.
        vecs.push_back(mk(1, 1, 12'h001, 0, 0, 12'h001, 0, 0, 0));
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 12'h000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 12'h999, 0, 0, 1));
        vecs.push_back(mk(1, 0, 12'h000, 0, 1, 12'h999, 0, 0, 1));
        vecs.push_back(mk(1, 0, 12'h000, 0, 1, 12'h999, 0, 0, 1));
        vecs.push_back(mk(1, 0, 12'h000, 0, 1, 12'h999, 0, 0, 0));
        // Load cancels a running pulse.
        vecs.push_back(mk(1, 1, 12'h001, 0, 0, 12'h001, 0, 0, 0));
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 12'h000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 12'h999, 0, 0, 1));
        vecs.push_back(mk(1, 1, 12'h500, 0, 0, 12'h500, 0, 0, 0));
        // Halt at terminal, BUZZ_LEN=2.
        vecs.push_back(mk(2, 1, 12'h098, 1, 0, 12'h098, 0, 0, 0));
        vecs.push_back(mk(2, 0, 12'h000, 1, 0, 12'h099, 1, 0, 0));
        vecs.push_back(mk(2, 0, 12'h000, 1, 0, 12'h099, 1, 1, 1));
        vecs.push_back(mk(2, 0, 12'h000, 0, 1, 12'h099, 0, 1, 1));
        vecs.push_back(mk(2, 0, 12'h000, 1, 0, 12'h099, 1, 1, 0));
        vecs.push_back(mk(2, 0, 12'h000, 0, 0, 12'h099, 0, 1, 0));
        vecs.push_back(mk(2, 1, 12'h010, 1, 0, 12'h010, 0, 0, 0));
        vecs.push_back(mk(2, 0, 12'h000, 1, 0, 12'h011, 0, 0, 0));
        vecs.push_back(mk(2, 1, 12'h001, 0, 0, 12'h001, 0, 0, 0));
        vecs.push_back(mk(2, 0, 12'h000, 0, 0, 12'h000, 1, 0, 0));
        vecs.push_back(mk(2, 0, 12'h000, 0, 0, 12'h000, 1, 1, 1));
        vecs.push_back(mk(2, 0, 12'h000, 0, 0, 12'h000, 1, 1, 1));
        vecs.push_back(mk(2, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0));
        // Stop at terminal is not a terminal event.
        vecs.push_back(mk(2, 1, 12'h099, 1, 0, 12'h099, 1, 0, 0));
        vecs.push_back(mk(2, 0, 12'h000, 1, 1, 12'h099, 1, 0, 0));
        vecs.push_back(mk(2, 0, 12'h000, 1, 0, 12'h099, 1, 1, 1));

        reset = 1'b1;
        ld0 = 0; lv0 = '0; ud0 = 1; st0 = 0;
        ld1 = 0; lv1 = '0; ud1 = 1; st1 = 0;
        ld2 = 0; lv2 = '0; ud2 = 1; st2 = 0;
        #12;
        chk("reset u0 digits", {4'h0, dig0}, 12'h000);
        chk("reset u1 digits", dig1, 12'h000);
        chk("reset u0 buzzer", {11'd0, bz0}, 12'd0);
        chk("reset u2 halted", {11'd0, h2}, 12'd0);
        chk("reset u0 tc", {11'd0, tc0}, 12'd0);
        reset = 1'b0;

        // Asynchronous reset mid-count, checked before any clock edge.
        step(mk(0, 1, 12'h047, 1, 0, 12'h047, 0, 0, 0));
        step(mk(1, 1, 12'h999, 1, 0, 12'h999, 1, 0, 0));
        step(mk(1, 0, 12'h000, 1, 0, 12'h000, 0, 0, 1));
        #1 reset = 1'b1;
        #1;
        chk("async reset u0 digits", {4'h0, dig0}, 12'h000);
        chk("async reset u1 digits", dig1, 12'h000);
        chk("async reset u1 buzzer", {11'd0, bz1}, 12'd0);
        #1 reset = 1'b0;

        foreach (vecs[i]) step(vecs[i]);

        // Second terminal event during a pulse restarts the pulse length.
        step(mk(1, 1, 12'h998, 1, 0, 12'h998, 0, 0, 0));
        step(mk(1, 0, 12'h000, 1, 0, 12'h999, 1, 0, 0));
        step(mk(1, 0, 12'h000, 1, 0, 12'h000, 0, 0, 1));
        step(mk(1, 0, 12'h000, 0, 0, 12'h999, 0, 0, 1));
        step(mk(1, 0, 12'h000, 0, 0, 12'h998, 0, 0, 1));
        step(mk(1, 0, 12'h000, 0, 0, 12'h997, 0, 0, 1));
        step(mk(1, 0, 12'h000, 0, 0, 12'h996, 0, 0, 0));

        chk("scoreboard empty", 12'(sb.size()), 12'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
